posit_encode_16_1: RTL and testbench
====================================

// Module: posit_encode_16_1
// PURPOSE
//  Consumer end of the denormalized-posit stream from the posit<16,1> arithmetic units (multiplier output).
//  Normalizes {sign, scale, fraction, NaR, zero} back to a 16-bit posit: clamp, regime/exponent build, RNE round, negate.
//  Same rtr/rts/sow/eow slave/master handshake and skid latch as the arithmetic blocks; 2-stage pipeline.
// PARAMETERS
//  N        16  posit width (only default verified)
//  ES       1   exponent field width
//  FRAC_W   26  input fraction width, MSB-aligned, hidden bit already removed
//  SCALE_W  7   input signed scale width
// PORTS
//  clk         in   1        clock
//  rst         in   1        synchronous, active-high reset
//  rtr_o       out  1        slave: ready to receive (registered)
//  rts_i       in   1        slave: upstream ready to send
//  sow_i       in   1        start-of-window tag
//  eow_i       in   1        end-of-window tag
//  fraction_i  in   FRAC_W   fraction bits below hidden 1, MSB = weight 2^-1
//  scale_i     in   SCALE_W  signed scale (2^scale)
//  NaR_i       in   1        not-a-real
//  sign_i      in   1        1 = negative
//  zero_i      in   1        value is zero
//  rtr_i       in   1        master: downstream ready to receive
//  rts_o       out  1        master: output valid
//  sow_o       out  1        sow tag aligned with posit_o
//  eow_o       out  1        eow tag aligned with posit_o
//  posit_o     out  N        encoded posit
// BEHAVIOUR
//  Reset: rtr_o=0, rts_o=0, sow_o=0, eow_o=0, posit_o=0; skid latch and both stage valids cleared.
//  process_en = rtr_i | ~rts_o; receive_en = rts_i & rtr_o; rtr_o <= process_en each cycle.
//  Skid: receive_en & ~process_en captures all inputs into latch; latch cleared on process_en. Stage-1 input = latch when set.
//  Stage k loads when process_en & (upstream valid); clears valid when process_en & no upstream. Stall holds all stages.
//  Latency 2 cycles accept->rts_o; throughput 1/cycle with rtr_i=1; no drop/duplicate under any rtr_i pattern.
//  Stage 1: clamp scale to [-28,+28] (MAXSCALE=(N-2)<<ES), set sat_hi/sat_lo flags; k = scale>>>ES, e = scale[ES-1:0].
//   Regime k>=0: (k+1) ones then 0; k<0: (-k) zeros then 1. Shift {regime,e,fraction} into 15-bit magnitude + guard + sticky.
//  Stage 2: RNE: inc = guard & (lsb | sticky); magnitude +inc.
//   Carry into bit 15 suppressed (result 0x7FFF); magnitude 0 forced to 0x0001 (posits never round to 0 or NaR).
//   sat_hi -> 0x7FFF, sat_lo -> 0x0001 regardless of fraction. sign=1 -> two's complement of {0,magnitude}.
//  Priority: NaR_i -> 0x8000; else zero_i -> 0x0000; else encode. NaR_i & zero_i -> 0x8000.
//  sow/eow travel with data unchanged. Reset mid-stream discards latch and in-flight data; no output next cycle.
// CONFIGURATION
//  POSIT_ENCODE_RNE_EN defined: round-to-nearest-even as above.
//  Not defined: truncate (inc=0), guard/sticky logic removed; saturation and never-zero rules still apply.
// STRUCTURE
//  posit_pkg: POSIT_N, POSIT_ES, MAXSCALE, POSIT_NAR=16'h8000, POSIT_MAXPOS=16'h7FFF, POSIT_MINPOS=16'h0001,
//   typedef struct posit_denorm_t {sign, NaR, zero, scale, fraction}.
//  One sub-module natural: posit_round_rne (combinational magnitude+guard+sticky -> rounded magnitude, saturation).
// TESTING
//  scale=0, frac=0 -> 0x4000; scale=1 -> 0x5000; scale=2 -> 0x6000; frac=26'h2000000 scale=0 -> 0x4800.
//  sign=1, scale=0, frac=0 -> 0xC000; NaR_i=1 (any) -> 0x8000; zero_i=1 -> 0x0000; NaR&zero -> 0x8000.
//  scale=0: frac=26'h0002000 -> 0x4000 (tie even); 26'h0006000 -> 0x4002; 26'h0002001 -> 0x4001; without macro all -> 0x4000/0x4001/0x4000.
//  scale=+60 -> 0x7FFF; scale=28 frac=all-ones -> 0x7FFF (no wrap); scale=-60 -> 0x0001; scale=-60 sign=1 -> 0xFFFF.
//  Stream 8 tagged operands (sow on first, eow on last), rtr_i random 50% -> all 8 out in order, tags aligned, latency 2 when unstalled.
//  rts_i=1 while rtr_i=0 for 5 cycles then released -> skid latch holds exactly one item, no loss; rst asserted mid-stream -> rts_o=0 next cycle.

Source files
------------

// File: rtl/posit_pkg.sv
// posit<16,1> shared constants and the denormalized operand bundle.
// Used by posit_encode_16_1 and posit_round_rne.
package posit_pkg;

  localparam int POSIT_N       = 16;
  localparam int POSIT_ES      = 1;
  localparam int POSIT_FRAC_W  = 26;
  localparam int POSIT_SCALE_W = 7;
  localparam int MAXSCALE      = (POSIT_N - 2) << POSIT_ES;

  localparam logic [POSIT_N-1:0] POSIT_NAR    = 16'h8000;
  localparam logic [POSIT_N-1:0] POSIT_MAXPOS = 16'h7FFF;
  localparam logic [POSIT_N-1:0] POSIT_MINPOS = 16'h0001;

  typedef struct packed {
    logic                     sign;
    logic                     NaR;
    logic                     zero;
    logic [POSIT_SCALE_W-1:0] scale;
    logic [POSIT_FRAC_W-1:0]  fraction;
  } posit_denorm_t;

endpackage

// File: rtl/posit_round_rne.sv
// Rounds a 15-bit posit magnitude and applies saturation rules.
// POSIT_ENCODE_RNE_EN selects round-to-nearest-even, else truncate.
module posit_round_rne
  import posit_pkg::*;
(
  input  logic [POSIT_N-2:0] mag_i,
  input  logic               guard_i,
  input  logic               sticky_i,
  input  logic               sat_hi_i,
  input  logic               sat_lo_i,
  output logic [POSIT_N-2:0] mag_o
);

  logic               inc;
  logic [POSIT_N-1:0] sum;

`ifdef POSIT_ENCODE_RNE_EN
  assign inc = guard_i & (mag_i[0] | sticky_i);
`else
  logic unused_gs;
  assign unused_gs = guard_i | sticky_i;
  assign inc = 1'b0;
`endif

  assign sum = {1'b0, mag_i} + {{(POSIT_N-1){1'b0}}, inc};

  // Posits never round to zero or wrap into NaR.
  always_comb begin
    mag_o = sum[POSIT_N-2:0];
    if (sat_hi_i)
      mag_o = POSIT_MAXPOS[POSIT_N-2:0];
    else if (sat_lo_i)
      mag_o = POSIT_MINPOS[POSIT_N-2:0];
    else if (sum[POSIT_N-1])
      mag_o = POSIT_MAXPOS[POSIT_N-2:0];
    else if (sum[POSIT_N-2:0] == '0)
      mag_o = POSIT_MINPOS[POSIT_N-2:0];
  end

endmodule

// File: rtl/posit_encode_16_1.sv
// Denormalized posit<16,1> -> 16-bit posit encoder, 2-stage pipeline.
// Rounding mode selected by POSIT_ENCODE_RNE_EN (truncate if undefined).
module posit_encode_16_1
  import posit_pkg::*;
#(
  parameter int N       = POSIT_N,
  parameter int ES      = POSIT_ES,
  parameter int FRAC_W  = POSIT_FRAC_W,
  parameter int SCALE_W = POSIT_SCALE_W
) (
  input  logic               clk,
  input  logic               rst,
  output logic               rtr_o,
  input  logic               rts_i,
  input  logic               sow_i,
  input  logic               eow_i,
  input  logic [FRAC_W-1:0]  fraction_i,
  input  logic [SCALE_W-1:0] scale_i,
  input  logic               NaR_i,
  input  logic               sign_i,
  input  logic               zero_i,
  input  logic               rtr_i,
  output logic               rts_o,
  output logic               sow_o,
  output logic               eow_o,
  output logic [N-1:0]       posit_o
);

  localparam int VW = 2 + ES + FRAC_W + N - 1;
  localparam logic signed [SCALE_W-1:0] MAX_SC =
    SCALE_W'(MAXSCALE);

  logic process_en;
  logic receive_en;

  assign process_en = rtr_i | ~rts_o;
  assign receive_en = rts_i & rtr_o;

  posit_denorm_t in_d;
  posit_denorm_t skid_d;
  posit_denorm_t s1_d;
  logic          skid_v;
  logic          skid_sow;
  logic          skid_eow;
  logic          s1_up;
  logic          s1_sow_in;
  logic          s1_eow_in;

  always_comb begin
    in_d.sign     = sign_i;
    in_d.NaR      = NaR_i;
    in_d.zero     = zero_i;
    in_d.scale    = scale_i;
    in_d.fraction = fraction_i;
  end

  // Catches the one item accepted in the cycle downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      rtr_o    <= 1'b0;
      skid_v   <= 1'b0;
      skid_d   <= '0;
      skid_sow <= 1'b0;
      skid_eow <= 1'b0;
    end else begin
      rtr_o <= process_en;
      if (process_en) begin
        skid_v <= 1'b0;
      end else if (receive_en) begin
        skid_v   <= 1'b1;
        skid_d   <= in_d;
        skid_sow <= sow_i;
        skid_eow <= eow_i;
      end
    end
  end

  assign s1_up     = skid_v | receive_en;
  assign s1_d      = skid_v ? skid_d : in_d;
  assign s1_sow_in = skid_v ? skid_sow : sow_i;
  assign s1_eow_in = skid_v ? skid_eow : eow_i;

  logic signed [SCALE_W-1:0] sc_in;
  logic signed [SCALE_W-1:0] sc;
  logic signed [4:0]         k;
  logic [4:0]                sh;
  logic                      sat_hi;
  logic                      sat_lo;
  logic signed [VW-1:0]      body;
  logic signed [VW-1:0]      shifted;

  // Leading 2'b10 / 2'b01 is sign-extended by the shift into the regime.
  always_comb begin
    sc_in  = $signed(s1_d.scale);
    sc     = sc_in;
    sat_hi = 1'b0;
    sat_lo = 1'b0;
    if (sc_in > MAX_SC) begin
      sc     = MAX_SC;
      sat_hi = 1'b1;
    end else if (sc_in < -MAX_SC) begin
      sc     = -MAX_SC;
      sat_lo = 1'b1;
    end
    k       = 5'(sc >>> ES);
    sh      = k[4] ? ~k : k;
    body    = {k[4] ? 2'b01 : 2'b10, sc[ES-1:0],
               s1_d.fraction, {(N-1){1'b0}}};
    shifted = body >>> sh;
  end

  logic         s1_v;
  logic         s1_sign;
  logic         s1_nar;
  logic         s1_zero;
  logic         s1_sat_hi;
  logic         s1_sat_lo;
  logic [N-2:0] s1_mag;
  logic         s1_guard;
  logic         s1_sticky;
  logic         s1_sow;
  logic         s1_eow;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v      <= 1'b0;
      s1_sign   <= 1'b0;
      s1_nar    <= 1'b0;
      s1_zero   <= 1'b0;
      s1_sat_hi <= 1'b0;
      s1_sat_lo <= 1'b0;
      s1_mag    <= '0;
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
      s1_sow    <= 1'b0;
      s1_eow    <= 1'b0;
    end else if (process_en) begin
      s1_v <= s1_up;
      if (s1_up) begin
        s1_sign   <= s1_d.sign;
        s1_nar    <= s1_d.NaR;
        s1_zero   <= s1_d.zero;
        s1_sat_hi <= sat_hi;
        s1_sat_lo <= sat_lo;
        s1_mag    <= shifted[VW-1 -: N-1];
        s1_guard  <= shifted[VW-N];
        s1_sticky <= |shifted[VW-N-1:0];
        s1_sow    <= s1_sow_in;
        s1_eow    <= s1_eow_in;
      end
    end
  end

  logic [N-2:0] rnd_mag;
  logic [N-1:0] posit_d;

  posit_round_rne u_round (
    .mag_i    (s1_mag),
    .guard_i  (s1_guard),
    .sticky_i (s1_sticky),
    .sat_hi_i (s1_sat_hi),
    .sat_lo_i (s1_sat_lo),
    .mag_o    (rnd_mag)
  );

  always_comb begin
    posit_d = {1'b0, rnd_mag};
    if (s1_nar)
      posit_d = POSIT_NAR;
    else if (s1_zero)
      posit_d = '0;
    else if (s1_sign)
      posit_d = -{1'b0, rnd_mag};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rts_o   <= 1'b0;
      sow_o   <= 1'b0;
      eow_o   <= 1'b0;
      posit_o <= '0;
    end else if (process_en) begin
      rts_o <= s1_v;
      if (s1_v) begin
        posit_o <= posit_d;
        sow_o   <= s1_sow;
        eow_o   <= s1_eow;
      end
    end
  end

endmodule

// File: tb/tb_posit_encode_16_1.sv
// Scoreboard bench for posit_encode_16_1 with directed vectors.
// Expected values follow POSIT_ENCODE_RNE_EN when it is defined.
module tb_posit_encode_16_1;

  logic        clk = 1'b0;
  logic        rst;
  logic        rtr_o;
  logic        rts_i;
  logic        sow_i;
  logic        eow_i;
  logic [25:0] fraction_i;
  logic [6:0]  scale_i;
  logic        NaR_i;
  logic        sign_i;
  logic        zero_i;
  logic        rtr_i = 1'b1;
  logic        rts_o;
  logic        sow_o;
  logic        eow_o;
  logic [15:0] posit_o;

  posit_encode_16_1 dut (
    .clk        (clk),
    .rst        (rst),
    .rtr_o      (rtr_o),
    .rts_i      (rts_i),
    .sow_i      (sow_i),
    .eow_i      (eow_i),
    .fraction_i (fraction_i),
    .scale_i    (scale_i),
    .NaR_i      (NaR_i),
    .sign_i     (sign_i),
    .zero_i     (zero_i),
    .rtr_i      (rtr_i),
    .rts_o      (rts_o),
    .sow_o      (sow_o),
    .eow_o      (eow_o),
    .posit_o    (posit_o)
  );

  always #5 clk = ~clk;

`ifdef POSIT_ENCODE_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  typedef struct packed {
    logic [25:0] frac;
    logic [6:0]  scale;
    logic        nar;
    logic        sign;
    logic        zero;
    logic [15:0] er;
    logic [15:0] et;
  } vec_t;

  typedef struct packed {
    logic [15:0] posit;
    logic        sow;
    logic        eow;
    logic        chk_lat;
    longint      t;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   outs = 0;
  int   accepted = 0;
  bit   rnd_mode = 1'b0;
  bit   hold = 1'b0;
  bit   lat_chk = 1'b1;

  task automatic chk(input string name, input logic [15:0] got,
                     input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic send(input vec_t v, input logic sw, input logic ew);
    int   n;
    exp_t e;
    @(negedge clk);
    fraction_i = v.frac;
    scale_i    = v.scale;
    NaR_i      = v.nar;
    sign_i     = v.sign;
    zero_i     = v.zero;
    sow_i      = sw;
    eow_i      = ew;
    rts_i      = 1'b1;
    n = 0;
    while (!rtr_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rtr_o) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got rtr_o=0 want 1");
      rts_i = 1'b0;
    end else begin
      e.posit   = RNE ? v.er : v.et;
      e.sow     = sw;
      e.eow     = ew;
      e.chk_lat = lat_chk;
      e.t       = longint'($time);
      sb.push_back(e);
      pushed++;
      accepted++;
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    rts_i = 1'b0;
    sow_i = 1'b0;
    eow_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    #2;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rnd_mode) rtr_i = 1'($urandom_range(0, 1));
    else rtr_i = !hold;
    if (!rst && rts_o && rtr_i) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected got %h want none", posit_o);
      end else begin
        e = sb.pop_front();
        outs++;
        if ({posit_o, sow_o, eow_o} !== {e.posit, e.sow, e.eow}) begin
          errors++;
          $display("FAIL out got %h sow%b eow%b want %h sow%b eow%b",
                   posit_o, sow_o, eow_o, e.posit, e.sow, e.eow);
        end
        if (e.chk_lat) begin
          checks++;
          if (longint'($time) - e.t != 20) begin
            errors++;
            $display("FAIL latency got %0d want 20",
                     longint'($time) - e.t);
          end
        end
      end
    end
  end

  initial begin
    vt.push_back('{26'h0, 7'd0, 1'b0, 1'b0, 1'b0, 16'h4000, 16'h4000});
    vt.push_back('{26'h0, 7'd1, 1'b0, 1'b0, 1'b0, 16'h5000, 16'h5000});
    vt.push_back('{26'h0, 7'd2, 1'b0, 1'b0, 1'b0, 16'h6000, 16'h6000});
    vt.push_back('{26'h2000000, 7'd0, 1'b0, 1'b0, 1'b0,
                   16'h4800, 16'h4800});
    vt.push_back('{26'h0, 7'd0, 1'b0, 1'b1, 1'b0, 16'hC000, 16'hC000});
    vt.push_back('{26'h155AAAA, 7'd5, 1'b1, 1'b1, 1'b0,
                   16'h8000, 16'h8000});
    vt.push_back('{26'h1234567, 7'd3, 1'b0, 1'b0, 1'b1,
                   16'h0000, 16'h0000});
    vt.push_back('{26'h0, 7'd0, 1'b1, 1'b0, 1'b1, 16'h8000, 16'h8000});
    vt.push_back('{26'h0002000, 7'd0, 1'b0, 1'b0, 1'b0,
                   16'h4000, 16'h4000});
    vt.push_back('{26'h0006000, 7'd0, 1'b0, 1'b0, 1'b0,
                   16'h4002, 16'h4001});
    vt.push_back('{26'h0002001, 7'd0, 1'b0, 1'b0, 1'b0,
                   16'h4001, 16'h4000});
    vt.push_back('{26'h0, 7'd60, 1'b0, 1'b0, 1'b0, 16'h7FFF, 16'h7FFF});
    vt.push_back('{26'h3FFFFFF, 7'd28, 1'b0, 1'b0, 1'b0,
                   16'h7FFF, 16'h7FFF});
    vt.push_back('{26'h0, 7'(-60), 1'b0, 1'b0, 1'b0,
                   16'h0001, 16'h0001});
    vt.push_back('{26'h0, 7'(-60), 1'b0, 1'b1, 1'b0,
                   16'hFFFF, 16'hFFFF});
    vt.push_back('{26'h0, 7'(-1), 1'b0, 1'b0, 1'b0, 16'h3000, 16'h3000});
    vt.push_back('{26'h0, 7'(-2), 1'b0, 1'b0, 1'b0, 16'h2000, 16'h2000});
    vt.push_back('{26'h2000000, 7'd3, 1'b0, 1'b1, 1'b0,
                   16'h9400, 16'h9400});
    vt.push_back('{26'h0, 7'(-5), 1'b0, 1'b0, 1'b0, 16'h0C00, 16'h0C00});
    vt.push_back('{26'h0, 7'd27, 1'b0, 1'b0, 1'b0, 16'h7FFE, 16'h7FFE});
    vt.push_back('{26'h1, 7'd27, 1'b0, 1'b0, 1'b0, 16'h7FFF, 16'h7FFE});
    vt.push_back('{26'h3FFFFFF, 7'(-27), 1'b0, 1'b0, 1'b0,
                   16'h0002, 16'h0001});
    vt.push_back('{26'h0, 7'(-28), 1'b0, 1'b0, 1'b0,
                   16'h0001, 16'h0001});
    vt.push_back('{26'h3FFFFFF, 7'(-29), 1'b0, 1'b0, 1'b0,
                   16'h0001, 16'h0001});
    vt.push_back('{26'h0, 7'd29, 1'b0, 1'b1, 1'b0, 16'h8001, 16'h8001});

    rst = 1'b1;
    rts_i = 1'b0;
    sow_i = 1'b0;
    eow_i = 1'b0;
    fraction_i = '0;
    scale_i = '0;
    NaR_i = 1'b0;
    sign_i = 1'b0;
    zero_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rtr_o", {15'b0, rtr_o}, 16'h0);
    chk("rst_rts_o", {15'b0, rts_o}, 16'h0);
    chk("rst_sow_o", {15'b0, sow_o}, 16'h0);
    chk("rst_eow_o", {15'b0, eow_o}, 16'h0);
    chk("rst_posit_o", posit_o, 16'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++)
      send(vt[i], i == 0, i == vt.size() - 1);
    idle();
    drain();

    lat_chk = 1'b0;
    rnd_mode = 1'b1;
    for (int i = 0; i < 8; i++)
      send(vt[i + 9], i == 0, i == 7);
    idle();
    drain();
    rnd_mode = 1'b0;

    hold = 1'b1;
    accepted = 0;
    fork
      begin
        for (int i = 0; i < 5; i++)
          send(vt[i + 15], i == 0, i == 4);
        idle();
      end
      begin
        repeat (6) @(posedge clk);
        #3;
        chk("stall_accepted", 16'(accepted), 16'd3);
        chk("stall_rtr_o", {15'b0, rtr_o}, 16'h0);
        hold = 1'b0;
      end
    join
    drain();

    lat_chk = 1'b1;
    for (int i = 0; i < 3; i++)
      send(vt[i], 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    rts_i = 1'b0;
    pushed -= sb.size();
    sb.delete();
    @(posedge clk);
    #1;
    chk("midrst_rts_o", {15'b0, rts_o}, 16'h0);
    chk("midrst_rtr_o", {15'b0, rtr_o}, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("postrst_rts_o", {15'b0, rts_o}, 16'h0);
    send(vt[17], 1'b1, 1'b1);
    idle();
    drain();

    chk("out_count", 16'(outs), 16'(pushed));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

endmodule
